barrel_shift_pipe: RTL and testbench

Parametrised, pipelined barrel shifter with four shift modes and a valid/ready handshake on both sides. Each shift stage is one rank of 2:1 muxes selected by one bit of the shift amount, with a register after every stage, so the block closes timing at any WIDTH. It replaces the combinational 8-bit shifter in the datapath and feeds the ALU result bus.

---
 rtl/barrel_shift_pipe.sv | 98 +++++++++
 tb/tb_barrel_shift_pipe.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_shift_pipe.sv
// rtl/barrel_shift_pipe.sv - pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready on both sides
module barrel_shift_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;

  logic             st_valid [SHW];
  logic [WIDTH-1:0] st_data  [SHW];
  logic [SHW-1:0]   st_amt   [SHW];
  logic [1:0]       st_mode  [SHW];

  logic             src_valid [SHW];
  logic [WIDTH-1:0] src_data  [SHW];
  logic [SHW-1:0]   src_amt   [SHW];
  logic [1:0]       src_mode  [SHW];
  logic [WIDTH-1:0] nx_data   [SHW];

  logic advance;

  // One rank of muxes: fixed shift by sh. For SRA the MSB is still the
  // original sign bit at every rank, so it is the fill source.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                  input logic [1:0] mode,
                                                  input int sh);
    logic [WIDTH-1:0] ones;
    ones = '1;
    case (mode)
      MODE_SLL: shift_step = d << sh;
      MODE_SRL: shift_step = d >> sh;
      MODE_SRA: shift_step = (d >> sh) | ({WIDTH{d[WIDTH-1]}} & ~(ones >> sh));
      default:  shift_step = (d >> sh) | (d << (WIDTH - sh));
    endcase
  endfunction

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = st_valid[SHW-1];
  assign out_data  = st_data[SHW-1];

  always_comb begin
    for (int k = 0; k < SHW; k++) begin
      src_valid[k] = 1'b0;
      src_data[k]  = '0;
      src_amt[k]   = '0;
      src_mode[k]  = '0;
      nx_data[k]   = '0;
    end
    src_valid[0] = in_valid;
    src_data[0]  = in_data;
    src_amt[0]   = in_amt;
    src_mode[0]  = in_mode;
    for (int k = 1; k < SHW; k++) begin
      src_valid[k] = st_valid[k-1];
      src_data[k]  = st_data[k-1];
      src_amt[k]   = st_amt[k-1];
      src_mode[k]  = st_mode[k-1];
    end
    for (int k = 0; k < SHW; k++) begin
      nx_data[k] = src_amt[k][k] ? shift_step(src_data[k], src_mode[k], 1 << k)
                                 : src_data[k];
    end
  end

  // Global stall: the whole pipe moves together or holds together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SHW; k++) begin
        st_valid[k] <= 1'b0;
        st_data[k]  <= '0;
        st_amt[k]   <= '0;
        st_mode[k]  <= '0;
      end
    end else if (advance) begin
      for (int k = 0; k < SHW; k++) begin
        st_valid[k] <= src_valid[k];
        st_data[k]  <= nx_data[k];
        st_amt[k]   <= src_amt[k];
        st_mode[k]  <= src_mode[k];
      end
    end
  end

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// tb/tb_barrel_shift_pipe.sv - self-checking bench for barrel_shift_pipe against an arithmetic reference
module tb_barrel_shift_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic [1:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  logic        sw_valid;
  logic [3:0]  d4;
  logic [31:0] d32;
  logic [63:0] d64;
  logic        rdy4, rdy32, rdy64, v4, v32, v64;
  logic [3:0]  o4;
  logic [31:0] o32;
  logic [63:0] o64;

  int n_tests = 0;
  int n_fail  = 0;
  int n_cons  = 0;
  logic acc;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  barrel_shift_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));

  barrel_shift_pipe #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(rdy4),
    .in_data(d4), .in_amt(2'd3), .in_mode(2'b10),
    .out_valid(v4), .out_ready(1'b1), .out_data(o4));

  barrel_shift_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(rdy32),
    .in_data(d32), .in_amt(5'd31), .in_mode(2'b10),
    .out_valid(v32), .out_ready(1'b1), .out_data(o32));

  barrel_shift_pipe #(.WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(rdy64),
    .in_data(d64), .in_amt(6'd63), .in_mode(2'b10),
    .out_valid(v64), .out_ready(1'b1), .out_data(o64));

  function automatic logic [7:0] ref_shift(input logic [7:0] d, input int n, input logic [1:0] m);
    int v;
    int s;
    v = int'(d);
    s = (v >= 128) ? v - 256 : v;
    case (m)
      2'b00:   return 8'((v * (1 << n)) % 256);
      2'b01:   return 8'(v / (1 << n));
      2'b10:   return 8'(s >>> n);
      default: return 8'(((v >> n) | (v << (8 - n))) & 255);
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Evaluate both handshakes before the edge, then advance one clock.
  task automatic step();
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      check("q_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        check("stream_data", 64'(out_data), 64'(exp_q.pop_front()));
        n_cons++;
      end
    end
    if (acc && rst_n) exp_q.push_back(ref_shift(in_data, int'(in_amt), in_mode));
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input logic [7:0] d, input logic [2:0] a, input logic [1:0] m,
                          input logic [7:0] exp, input string tag);
    in_valid = 1'b1; in_data = d; in_amt = a; in_mode = m;
    step();
    in_valid = 1'b0;
    step();
    check({tag, "_early"}, 64'(out_valid), 64'd0);
    step();
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check(tag, 64'(out_data), 64'(exp));
    step();
  endtask

  initial begin
    logic [7:0] held;
    int cyc;
    int accepted;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = '0;
    out_ready = 1'b1; sw_valid = 1'b0; d4 = '0; d32 = '0; d64 = '0;

    for (int i = 0; i < 4; i++) begin
      in_valid = 1'($urandom); in_data = 8'($urandom); in_amt = 3'($urandom);
      in_mode = 2'($urandom); out_ready = 1'($urandom);
      @(posedge clk); #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    rst_n = 1'b1;

    directed(8'h81, 3'd1, 2'b00, 8'h02, "reset_sll");
    directed(8'hB4, 3'd3, 2'b00, 8'hA0, "sweep_sll");
    directed(8'hB4, 3'd3, 2'b01, 8'h16, "sweep_srl");
    directed(8'hB4, 3'd3, 2'b10, 8'hF6, "sweep_sra");
    directed(8'hB4, 3'd3, 2'b11, 8'h96, "sweep_ror");
    for (int m = 0; m < 4; m++) directed(8'hB4, 3'd0, 2'(m), 8'hB4, "sweep_amt0");
    step(); step();

    n_cons = 0;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom); in_amt = 3'($urandom); in_mode = 2'($urandom);
      step();
      check("stream_in_ready", 64'(acc), 64'd1);
    end
    in_valid = 1'b0;
    step(); step(); step();
    check("stream_count", 64'(n_cons), 64'd256);
    check("stream_drained", 64'(out_valid), 64'd0);

    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom); in_amt = 3'($urandom); in_mode = 2'($urandom);
      step();
    end
    out_ready = 1'b0;
    in_data = 8'h5A; in_amt = 3'd2; in_mode = 2'b11;
    #1;
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_out_hold", 64'(out_data), 64'(held));
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("bp_q_empty", 64'(exp_q.size()), 64'd0);

    accepted = 0; cyc = 0;
    in_valid = 1'b0;
    while (accepted < 1000 && cyc < 20000) begin
      if (!in_valid || acc) begin
        in_valid = 1'($urandom); in_data = 8'($urandom);
        in_amt = 3'($urandom); in_mode = 2'($urandom);
      end
      out_ready = 1'($urandom);
      step();
      if (acc) accepted++;
      cyc++;
    end
    check("rand_accepted", 64'(accepted), 64'd1000);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("rand_q_empty", 64'(exp_q.size()), 64'd0);

    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom); in_amt = 3'($urandom); in_mode = 2'($urandom);
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("midrst_no_valid", 64'(out_valid), 64'd0);
    end

    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hB4; in_amt = 3'd0; in_mode = 2'b00;
    step();
    in_valid = 1'b0;
    step(); step();
    check("async_pre_valid", 64'(out_valid), 64'd1);
    check("async_pre_data", 64'(out_data), 64'hB4);
    rst_n = 1'b0;
    #2;
    check("async_valid", 64'(out_valid), 64'd0);
    check("async_data", 64'(out_data), 64'd0);
    check("async_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;

    sw_valid = 1'b1; d4 = 4'h8; d32 = 32'h8000_0000; d64 = 64'h8000_0000_0000_0000;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk); #1;
      sw_valid = 1'b0;
      check("w4_valid", 64'(v4), 64'(e == 2));
      check("w32_valid", 64'(v32), 64'(e == 5));
      check("w64_valid", 64'(v64), 64'(e == 6));
      if (e == 2) check("w4_sra", 64'(o4), 64'hF);
      if (e == 5) check("w32_sra", 64'(o32), 64'hFFFF_FFFF);
      if (e == 6) check("w64_sra", o64, 64'hFFFF_FFFF_FFFF_FFFF);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
